router_fifo: RTL

- 16-deep byte FIFO that sits directly downstream of the router's register stage; one instance per output port of the 1x3 router.
- Captures `dout` bytes from the register stage together with a header-marker bit (`lfd_state`).
- Serves the bytes to the destination reader.
- Tracks remaining packet length from the header, so the output bus returns to zero once a full packet has been drained.

---
 rtl/router_pkg.sv | 27 ++
 rtl/router_fifo_ptr.sv | 22 ++
 rtl/router_fifo.sv | 79 +++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and types for the router output FIFOs.
// A FIFO entry is a byte plus its header flag.
package router_pkg;

   localparam int unsigned FIFO_DEPTH  = 16;
   localparam int unsigned FIFO_ADDR_W = 4;
   localparam int unsigned BYTE_W      = 8;

   // Header byte layout: LEN in [7:2], ADDR in [1:0]
   typedef struct packed {
      logic [5:0] len;
      logic [1:0] addr;
   } hdr_t;

   typedef struct packed {
      logic              hdr;
      logic [BYTE_W-1:0] data;
   } fifo_entry_t;

   // Bytes still to come after the header: payload length plus the parity byte
   function automatic logic [6:0] pkt_len(input logic [BYTE_W-1:0] hdr_byte);
      hdr_t h;
      h = hdr_t'(hdr_byte);
      return {1'b0, h.len} + 7'd1;
   endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// FIFO pointer with a wrap bit above the address bits.
// Counts modulo 2*DEPTH; synchronous clear takes priority over the increment.
module router_fifo_ptr #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            clear,
   input  logic            enb,
   output logic [ADDR_W:0] ptr
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         ptr <= '0;
      else if (clear)
         ptr <= '0;
      else if (enb)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/router_fifo.sv
// Per-port byte FIFO of the 1x3 router with header-driven packet length tracking.
// data_out clears to zero once the packet being served has been fully drained.
module router_fifo
   import router_pkg::*;
#(
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned ADDR_W = FIFO_ADDR_W,
   parameter int unsigned WIDTH  = BYTE_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] data_out
);

   fifo_entry_t     mem [DEPTH];
   fifo_entry_t     rd_entry;
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [6:0]      pkt_cnt;
   logic            do_wr;
   logic            do_rd;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

   // Both requests are qualified by the pre-edge flags; soft_reset drops them
   assign do_wr = write_enb && !full  && !soft_reset;
   assign do_rd = read_enb  && !empty && !soft_reset;

   assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

   router_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
      .clk    (clk),
      .resetn (resetn),
      .clear  (soft_reset),
      .enb    (do_wr),
      .ptr    (wr_ptr)
   );

   router_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
      .clk    (clk),
      .resetn (resetn),
      .clear  (soft_reset),
      .enb    (do_rd),
      .ptr    (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr[ADDR_W-1:0]] <= '{hdr: lfd_state, data: data_in};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pkt_cnt  <= '0;
         data_out <= '0;
      end else if (soft_reset) begin
         pkt_cnt  <= '0;
         data_out <= '0;
      end else if (do_rd) begin
         data_out <= rd_entry.data;
         if (rd_entry.hdr)
            pkt_cnt <= pkt_len(rd_entry.data);
         else if (pkt_cnt != '0)
            pkt_cnt <= pkt_cnt - 7'd1;
      end else if (pkt_cnt == '0) begin
         data_out <= '0;
      end
   end

endmodule
